// File: rtl/cordic_vectoring.sv
// Sequential vectoring-mode CORDIC: (X, Y) -> atan2(Y, X) and gain-corrected magnitude.
// One micro-rotation per clock behind a start/done handshake.
module cordic_vectoring #(
    parameter int          ITER = 8,
    parameter logic [31:0] GAIN = 32'h26DD3B6A
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] vec_x,
    input  logic [31:0] vec_y,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] angle,
    output logic [31:0] mag
);

    typedef enum logic [1:0] {IDLE, ROT, SCALE} stateT;

    stateT state, stateNext;

    logic signed [34:0] x, y, z;
    logic [2:0]         iter;

    function automatic logic signed [34:0] toTwos(input logic [31:0] v);
        logic signed [34:0] m;
        m = {4'b0, v[30:0]};
        return v[31] ? -m : m;
    endfunction

    function automatic logic signed [34:0] atanRom(input logic [2:0] i);
        logic [31:0] a;
        case (i)
            3'd0:    a = 32'h3243F6A8;
            3'd1:    a = 32'h1DAC6705;
            3'd2:    a = 32'h0FADBAFC;
            3'd3:    a = 32'h07F56EA6;
            3'd4:    a = 32'h03FEAB76;
            3'd5:    a = 32'h01FFD55B;
            3'd6:    a = 32'h00FFFAAA;
            default: a = 32'h007FFF55;
        endcase
        return {3'b0, a};
    endfunction

    logic               domainErr;
    logic               lastIter;
    logic signed [34:0] dx, dy;
    logic signed [69:0] prod, prodSh;
    logic [30:0]        zAbs;
    logic [31:0]        angleNext, magNext;

    assign domainErr = vec_x[31] && (vec_x[30:0] != 31'd0);
    assign lastIter  = (iter == 3'(ITER - 1));
    assign dx        = x >>> iter;
    assign dy        = y >>> iter;

    // x is non-negative after the first rotation, so a negative product
    // can only come from corrupted state and is clamped to zero.
    assign prod   = 70'(x) * 70'($signed({3'b0, GAIN}));
    assign prodSh = prod >>> 30;
    assign zAbs   = 31'(z[34] ? -z : z);

    always_comb begin
        magNext   = 32'h0;
        angleNext = 32'h0;
        if (prod[69])
            magNext = 32'h0;
        else if (prodSh > 70'sd2147483647)
            magNext = 32'h7FFFFFFF;
        else
            magNext = {1'b0, 31'(prodSh)};
        if (zAbs != 31'd0)
            angleNext = {z[34], zAbs};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (start && !domainErr) stateNext = ROT;
            ROT:     if (lastIter) stateNext = SCALE;
            SCALE:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x     <= '0;
            y     <= '0;
            z     <= '0;
            iter  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            angle <= '0;
            mag   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (domainErr) begin
                            err   <= 1'b1;
                            angle <= '0;
                            mag   <= '0;
                            done  <= 1'b1;
                        end else begin
                            x    <= toTwos(vec_x);
                            y    <= toTwos(vec_y);
                            z    <= '0;
                            iter <= '0;
                            busy <= 1'b1;
                            err  <= 1'b0;
                        end
                    end
                end
                ROT: begin
                    if (y[34]) begin
                        x <= x - dy;
                        y <= y + dx;
                        z <= z - atanRom(iter);
                    end else begin
                        x <= x + dy;
                        y <= y - dx;
                        z <= z + atanRom(iter);
                    end
                    iter <= iter + 3'd1;
                end
                SCALE: begin
                    angle <= angleNext;
                    mag   <= magNext;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Bench for cordic_vectoring: directed corner cases plus random vectors
// checked against a real-number atan2/hypot reference.
module tb_cordic_vectoring;

    localparam int ITER = 8;
    localparam longint ANG_TOL = 64'h00820000 + 64;
    localparam longint MAG_MAX = 64'h7FFFFFFF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] vecX, vecY;
    logic        busy, done, err;
    logic [31:0] angle, mag;

    int nChecks = 0;
    int nFails  = 0;

    cordic_vectoring #(.ITER(ITER)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .vec_x(vecX), .vec_y(vecY),
        .busy(busy), .done(done), .err(err),
        .angle(angle), .mag(mag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs,
                         input longint exp, input longint tol);
        longint d;
        nChecks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            nFails++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) tol %0d",
                     tag, obs, obs, exp, exp, tol);
        end
    endtask

    function automatic real smToReal(input logic [31:0] v);
        real m;
        m = real'(v[30:0]) / 1073741824.0;
        return v[31] ? -m : m;
    endfunction

    function automatic longint smToInt(input logic [31:0] v);
        return v[31] ? -longint'(v[30:0]) : longint'(v[30:0]);
    endfunction

    // Reference: ideal atan2 / hypot, magnitude clipped to the output range
    task automatic checkResult(input string tag, input logic [31:0] vx,
                               input logic [31:0] vy);
        bit     expErr;
        real    xr, yr, a, m;
        longint ea, em;
        expErr = vx[31] && (vx[30:0] != 0);
        check({tag, ".err"}, longint'(err), longint'(expErr), 0);
        if (expErr) begin
            check({tag, ".angle"}, longint'(angle), 0, 0);
            check({tag, ".mag"}, longint'(mag), 0, 0);
        end else begin
            xr = smToReal(vx);
            yr = smToReal(vy);
            a  = $atan2(yr, xr);
            m  = $sqrt(xr * xr + yr * yr) * 1073741824.0;
            ea = longint'(a * 1073741824.0);
            em = (m > real'(MAG_MAX)) ? MAG_MAX : longint'(m);
            check({tag, ".angle"}, smToInt(angle), ea, ANG_TOL);
            check({tag, ".mag"}, longint'(mag), em, em / 500 + 64);
        end
        check({tag, ".magSign"}, longint'(mag[31]), 0, 0);
        check({tag, ".angNeg0"}, longint'(angle == 32'h80000000), 0, 0);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge
    task automatic startOp(input logic [31:0] vx, input logic [31:0] vy);
        start = 1'b1;
        vecX  = vx;
        vecY  = vy;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Edges counted after the accept edge until done is seen
    task automatic waitDone(input string tag, output int edges, output bit sawBusy);
        edges   = 0;
        sawBusy = 1'b0;
        while (!done && edges < 40) begin
            sawBusy |= busy;
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        if (!done)
            check({tag, ".timeout"}, 0, 1, 0);
    endtask

    task automatic runOne(input string tag, input logic [31:0] vx,
                          input logic [31:0] vy);
        int e;
        bit b;
        bit expErr;
        expErr = vx[31] && (vx[30:0] != 0);
        startOp(vx, vy);
        waitDone(tag, e, b);
        check({tag, ".latency"}, e, expErr ? 0 : ITER + 1, 0);
        if (expErr)
            check({tag, ".busyErr"}, longint'(b), 0, 0);
        checkResult(tag, vx, vy);
    endtask

    task automatic watchNoDone(input string tag, input int cycles);
        int n;
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (done) n++;
        end
        check(tag, n, 0, 0);
    endtask

    initial begin
        int e, e2;
        bit b;
        logic [31:0] rx, ry;

        reset_n = 1'b0;
        start   = 1'b0;
        vecX    = '0;
        vecY    = '0;
        repeat (3) @(negedge clock);
        check("rst.busy", longint'(busy), 0, 0);
        check("rst.done", longint'(done), 0, 0);
        check("rst.err", longint'(err), 0, 0);
        check("rst.angle", longint'(angle), 0, 0);
        check("rst.mag", longint'(mag), 0, 0);
        reset_n = 1'b1;
        @(negedge clock);

        runOne("t1", 32'h40000000, 32'h00000000);
        runOne("t2", 32'h40000000, 32'h40000000);
        check("t2.angAbs", smToInt(angle), 64'h3243F6A8, ANG_TOL);
        runOne("t3a", 32'h00000000, 32'hC0000000);
        check("t3a.sign", longint'(angle[31]), 1, 0);
        runOne("t3b", 32'h80000000, 32'hC0000000);
        check("t3b.sign", longint'(angle[31]), 1, 0);
        runOne("t4err", 32'hC0000000, 32'h10000000);
        runOne("t4next", 32'h40000000, 32'h20000000);

        // Saturation, starts ignored while busy, back-to-back accept
        startOp(32'h7FFFFFFF, 32'h7FFFFFFF);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock);
            @(negedge clock);
            start = (k < 5);
            vecX  = 32'h40000000;
            vecY  = 32'h00000000;
        end
        waitDone("t5", e, b);
        check("t5.latency", e + 5, ITER + 1, 0);
        check("t5.magSat", longint'(mag), MAG_MAX, 0);
        checkResult("t5", 32'h7FFFFFFF, 32'h7FFFFFFF);
        startOp(32'h40000000, 32'hC0000000);
        waitDone("t5b2b", e2, b);
        check("t5b2b.latency", e2, ITER + 1, 0);
        checkResult("t5b2b", 32'h40000000, 32'hC0000000);
        watchNoDone("t5.spurDone", 12);

        // Reset mid-operation
        startOp(32'h40000000, 32'h00000000);
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset_n = 1'b0;
        #1;
        check("t6.busy", longint'(busy), 0, 0);
        check("t6.done", longint'(done), 0, 0);
        check("t6.err", longint'(err), 0, 0);
        check("t6.angle", longint'(angle), 0, 0);
        check("t6.mag", longint'(mag), 0, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        watchNoDone("t6.noDone", 12);
        runOne("t6.rerun", 32'h40000000, 32'h00000000);

        for (int n = 0; n < 40; n++) begin
            rx = {1'b0, 31'($urandom >> $urandom_range(1, 7))};
            ry = {1'($urandom), 31'($urandom >> $urandom_range(1, 7))};
            case ($urandom_range(0, 7))
                0:       rx[31] = 1'b1;
                1:       rx = {1'($urandom), 31'd0};
                2:       ry[30:0] = 31'd0;
                default: ;
            endcase
            if (rx[30:0] < 31'h01000000 && ry[30:0] < 31'h01000000)
                ry[30:0] = ry[30:0] | 31'h10000000;
            runOne($sformatf("rnd%0d", n), rx, ry);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
